// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: walks a 16-bit register list lowest index first and
// issues one register-file access plus one data-memory access per cycle
// for LDM/STM-style multi-register transfers.
// Optional feature macro: BASE_WRITEBACK_EN. When defined, the block writes
// the updated base address back to base_reg after the last transfer. That
// writeback is skipped when a load already wrote base_reg from memory.
module reg_list_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        up,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    input  logic [3:0]  base_reg,
    output logic        busy,
    output logic        done,
    output logic [3:0]  read_addr1,
    input  logic [31:0] read_data1,
    output logic        wr_en,
    output logic [3:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic [31:0] mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Number of set bits in a register list (0..16).
    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, m[i]};
        end
        return cnt;
    endfunction

    // Index of the lowest set bit. Returns 0 for an empty mask.
    function automatic logic [3:0] lowest_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t      r_state;
    logic [15:0] r_mask;
    logic [31:0] r_addr;
    logic        r_is_load;

    logic [4:0]  w_n;
    logic [31:0] w_four_n;
    logic [3:0]  w_k;
    logic [15:0] w_mask_next;

    assign w_n         = popcount16(reg_list);
    assign w_four_n    = {25'd0, w_n, 2'b00};
    assign w_k         = lowest_idx(r_mask);
    // Clearing the lowest set bit gives the mask after the current transfer.
    assign w_mask_next = r_mask & (r_mask - 16'd1);

`ifdef BASE_WRITEBACK_EN
    logic [31:0] r_final;
    logic [3:0]  r_base_reg;
    logic        r_skip_wb;
`else
    logic        w_unused_base_reg;
    assign w_unused_base_reg = ^base_reg;
`endif

    // Sequencer state, remaining mask and running address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_mask     <= 16'd0;
            r_addr     <= 32'd0;
            r_is_load  <= 1'b0;
`ifdef BASE_WRITEBACK_EN
            r_final    <= 32'd0;
            r_base_reg <= 4'd0;
            r_skip_wb  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask    <= reg_list;
                        r_is_load <= is_load;
                        // Transfers always run at ascending addresses, so a
                        // decrement-before walk starts at the lowest address.
                        r_addr    <= up ? base_addr : (base_addr - w_four_n);
`ifdef BASE_WRITEBACK_EN
                        r_final    <= up ? (base_addr + w_four_n) : (base_addr - w_four_n);
                        r_base_reg <= base_reg;
                        r_skip_wb  <= is_load & reg_list[base_reg];
`endif
                        r_state   <= (w_n != 5'd0) ? S_XFER : S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_XFER: begin
                    r_mask <= w_mask_next;
                    r_addr <= r_addr + 32'd4;
                    if (w_mask_next == 16'd0) begin
`ifdef BASE_WRITEBACK_EN
                        r_state <= r_skip_wb ? S_DONE : S_WB;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_state <= S_XFER;
                    end
                end
`ifdef BASE_WRITEBACK_EN
                S_WB: begin
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; data paths pass through in XFER.
    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        read_addr1 = 4'd0;
        wr_en      = 1'b0;
        write_addr = 4'd0;
        write_data = 32'd0;
        mem_addr   = 32'd0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = 32'd0;
        case (r_state)
            S_XFER: begin
                mem_addr = r_addr;
                if (r_is_load) begin
                    mem_rd     = 1'b1;
                    wr_en      = 1'b1;
                    write_addr = w_k;
                    write_data = mem_rdata;
                end else begin
                    read_addr1 = w_k;
                    mem_wr     = 1'b1;
                    mem_wdata  = read_data1;
                end
            end
`ifdef BASE_WRITEBACK_EN
            S_WB: begin
                wr_en      = 1'b1;
                write_addr = r_base_reg;
                write_data = r_final;
            end
`endif
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench for reg_list_sequencer. Provides a behavioural register
// file and word memory, predicts the full per-cycle output trace of every
// operation from the transfer rules, and pins the model with literal checks.
module tb_reg_list_sequencer;

`ifdef BASE_WRITEBACK_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wr_en;
        logic [3:0]  write_addr;
        logic [31:0] write_data;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  read_addr1;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n, start, is_load, up;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  base_reg;
    logic        busy, done, wr_en, mem_rd, mem_wr;
    logic [3:0]  read_addr1, write_addr;
    logic [31:0] read_data1, write_data, mem_addr, mem_rdata, mem_wdata;

    logic [31:0] rf  [0:15];
    logic [31:0] mem [0:255];
    logic        pl_rf, pl_mem;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    int   checks = 0;
    int   errors = 0;
    int   busy_total = 0;
    int   done_total = 0;
    int   op_b0, op_d0;
    bit   chk_en = 1'b0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    reg_list_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .up(up),
        .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg),
        .busy(busy), .done(done), .read_addr1(read_addr1), .read_data1(read_data1),
        .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    assign read_data1 = rf[read_addr1];
    assign mem_rdata  = mem[mem_addr[9:2]];

    // Register file and memory: preload port has priority over DUT writes.
    always @(posedge clk) begin
        if (pl_rf) rf[pl_idx[3:0]] <= pl_val;
        else if (wr_en) rf[write_addr] <= write_data;
        if (pl_mem) mem[pl_idx] <= pl_val;
        else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        out_t a, e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                a = {busy, done, wr_en, write_addr, write_data, mem_rd, mem_wr,
                     mem_addr, mem_wdata, read_addr1};
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '0;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL trace t=%0t got=%h exp=%h", $time, a, e);
                end
                if (busy === 1'b1) busy_total++;
                if (done === 1'b1) done_total++;
            end
        end
    endtask

    task automatic poke_rf(input int idx, input logic [31:0] val);
        pl_rf = 1'b1; pl_idx = 8'(idx); pl_val = val;
        @(posedge clk); #1;
        pl_rf = 1'b0;
    endtask

    task automatic poke_mem(input int idx, input logic [31:0] val);
        pl_mem = 1'b1; pl_idx = 8'(idx); pl_val = val;
        @(posedge clk); #1;
        pl_mem = 1'b0;
    endtask

    // Expected trace: one entry per busy cycle, derived from the transfer rules.
    task automatic build_trace(input bit ld, input bit u, input logic [15:0] lst,
                               input logic [31:0] base, input logic [3:0] br);
        int          n, j;
        logic [31:0] sa, fa;
        out_t        v;
        n  = $countones(lst);
        sa = u ? base : base - 32'(4 * n);
        fa = u ? base + 32'(4 * n) : base - 32'(4 * n);
        j  = 0;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                v = '0;
                v.busy = 1'b1;
                v.mem_addr = sa + 32'(4 * j);
                if (ld) begin
                    v.mem_rd = 1'b1; v.wr_en = 1'b1;
                    v.write_addr = 4'(i);
                    v.write_data = mem[v.mem_addr[9:2]];
                end else begin
                    v.mem_wr = 1'b1;
                    v.read_addr1 = 4'(i);
                    v.mem_wdata = rf[i];
                end
                exp_q.push_back(v);
                j++;
            end
        end
        if (WB_ON && n > 0 && !(ld && lst[br])) begin
            v = '0;
            v.busy = 1'b1; v.wr_en = 1'b1; v.write_addr = br; v.write_data = fa;
            exp_q.push_back(v);
        end
        v = '0;
        v.busy = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 of the first busy cycle.
    task automatic start_op(input bit ld, input bit u, input logic [15:0] lst,
                            input logic [31:0] base, input logic [3:0] br);
        is_load = ld; up = u; reg_list = lst; base_addr = base; base_reg = br;
        start = 1'b1;
        op_b0 = busy_total; op_d0 = done_total;
        @(posedge clk); #1;
        start = 1'b0;
        is_load = ~ld; up = ~u; reg_list = ~lst; base_addr = 32'h5A5A_0000;
        base_reg = br + 4'd1;
        build_trace(ld, u, lst, base, br);
    endtask

    task automatic finish_op(output int bcnt, output int dcnt);
        bit idle_seen;
        idle_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
        end
        #1;
        if (!idle_seen) chk("timeout_busy", 32'(busy), 32'd0);
        bcnt = busy_total - op_b0;
        dcnt = done_total - op_d0;
        @(posedge clk); #1;
    endtask

    initial begin
        int bc, dc;
        reset_n = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0;
        reg_list = 16'd0; base_addr = 32'd0; base_reg = 4'd0;
        pl_rf = 1'b0; pl_mem = 1'b0; pl_idx = 8'd0; pl_val = 32'd0;
        fork
            compare_loop();
        join_none
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 16; i++) poke_rf(i, 32'h1000_0000 + 32'(i));

        // Store, up, r0/r2 to 0x100/0x104.
        poke_rf(0, 32'hAAAA_AAAA);
        poke_rf(2, 32'h5555_5555);
        start_op(1'b0, 1'b1, 16'h0005, 32'h0000_0100, 4'd13);
        finish_op(bc, dc);
        chk("t1_mem100", mem[64], 32'hAAAA_AAAA);
        chk("t1_mem104", mem[65], 32'h5555_5555);
        chk("t1_r13", rf[13], WB_ON ? 32'h0000_0108 : 32'h1000_000D);
        chk("t1_busy_cycles", 32'(bc), WB_ON ? 32'd4 : 32'd3);
        chk("t1_done_count", 32'(dc), 32'd1);

        // Load, down, r0/r15 from 0x1F8/0x1FC.
        poke_rf(13, 32'h1313_1313);
        poke_mem(126, 32'h0000_0011);
        poke_mem(127, 32'h0000_0022);
        start_op(1'b1, 1'b0, 16'h8001, 32'h0000_0200, 4'd13);
        finish_op(bc, dc);
        chk("t2_r0", rf[0], 32'h0000_0011);
        chk("t2_r15", rf[15], 32'h0000_0022);
        chk("t2_r13", rf[13], WB_ON ? 32'h0000_01F8 : 32'h1313_1313);

        // Empty list: IDLE -> DONE -> IDLE.
        start_op(1'b1, 1'b1, 16'h0000, 32'h0000_0040, 4'd13);
        finish_op(bc, dc);
        chk("t3_busy_cycles", 32'(bc), 32'd1);
        chk("t3_done_count", 32'(dc), 32'd1);

        // Address wrap, store, up.
        poke_rf(0, 32'h0A0A_0A0A);
        poke_rf(1, 32'h1B1B_1B1B);
        poke_rf(13, 32'h1313_1313);
        start_op(1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC, 4'd13);
        finish_op(bc, dc);
        chk("t4_memFFFFFFFC", mem[255], 32'h0A0A_0A0A);
        chk("t4_mem0", mem[0], 32'h1B1B_1B1B);
        chk("t4_r13", rf[13], WB_ON ? 32'h0000_0004 : 32'h1313_1313);

        // Reset during the second transfer of a four-register store.
        poke_mem(192, 32'hDEAD_00C0);
        poke_mem(193, 32'hDEAD_00C1);
        start_op(1'b0, 1'b1, 16'h000F, 32'h0000_0300, 4'd13);
        @(posedge clk); #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("t5_rst_wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_first_committed", mem[192], 32'h0A0A_0A0A);
        chk("t5_second_dropped", mem[193], 32'hDEAD_00C1);
        start_op(1'b0, 1'b1, 16'h0001, 32'h0000_0310, 4'd13);
        finish_op(bc, dc);
        chk("t5_restart_mem", mem[196], 32'h0A0A_0A0A);
        chk("t5_restart_busy", 32'(bc), WB_ON ? 32'd3 : 32'd2);

        // Load with base_reg in the list; a start pulse mid-operation is ignored.
        poke_mem(80, 32'h0000_0077);
        poke_mem(81, 32'h0000_0088);
        start_op(1'b1, 1'b1, 16'h2001, 32'h0000_0140, 4'd13);
        start = 1'b1; reg_list = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(bc, dc);
        chk("t6_r0", rf[0], 32'h0000_0077);
        chk("t6_r13", rf[13], 32'h0000_0088);
        chk("t6_busy_cycles", 32'(bc), 32'd3);
        chk("t6_done_count", 32'(dc), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
